// File: rtl/multicycle_mem_pkg.sv
// Shared CPU constants: bus widths plus the default geometry and read latency
// of the multicycle data memory.
package multicycle_mem_pkg;

    localparam int CPU_DWIDTH = 16;
    localparam int CPU_AWIDTH = 16;
    localparam int MEM_DEPTH  = 1024;
    localparam int MEM_LAT    = 4;

endpackage

// File: rtl/multicycle_mem_lat_pipe.sv
// LAT-deep valid/data shift register for the read return path; output data holds
// when no valid reaches the last stage. clr_i drops in-flight entries but still loads a new one.
module lat_pipe #(
    parameter int W   = 16,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    output logic         any_vld_o
);

    logic [LAT-1:0] vld_q, vld_d;
    logic [W-1:0]   dat_q [LAT];
    logic [W-1:0]   dat_d [LAT];

    always_comb begin
        vld_d = {vld_q[LAT-2:0], in_vld_i};
        dat_d = dat_q;
        if (clr_i) begin
            vld_d[LAT-1:1] = '0;
        end
        if (in_vld_i) begin
            dat_d[0] = in_dat_i;
        end
        // A stage only advances on a live entry, so the last stage holds its value between responses.
        for (int i = 1; i < LAT; i++) begin
            if (vld_q[i-1] && !clr_i) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld_o = vld_q[LAT-1];
    assign out_dat_o = dat_q[LAT-1];
    assign any_vld_o = |vld_q;

endmodule

// File: rtl/multicycle_mem.sv
// Word memory with a fixed LAT-cycle pipelined read path and flush; writes commit at accept.
// Never back-pressures: req_ready is low only while rst is asserted.
module multicycle_mem
    import multicycle_mem_pkg::*;
#(
    parameter int DWIDTH = CPU_DWIDTH,
    parameter int AWIDTH = CPU_AWIDTH,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int LAT    = MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_data,
    output logic              busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] word_idx;
    logic [IW-1:0]     mem_idx;
    logic              accept, rd_acc, wr_acc;

    assign req_ready = ~rst;
    assign accept    = req_valid & req_ready;
    assign rd_acc    = accept & ~req_wr;
    assign wr_acc    = accept &  req_wr;

    // Byte address to word index; the odd-byte bit is dropped and indices wrap at DEPTH.
    assign word_idx = req_addr >> 1;
    assign mem_idx  = IW'(word_idx % AWIDTH'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[mem_idx] <= req_wdata;
        end
    end

    lat_pipe #(
        .W   (DWIDTH),
        .LAT (LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .in_vld_i  (rd_acc),
        .in_dat_i  (mem_q[mem_idx]),
        .out_vld_o (resp_valid),
        .out_dat_o (resp_data),
        .any_vld_o (busy)
    );

endmodule

// File: tb/tb_multicycle_mem.sv
// Directed bench for multicycle_mem with default parameters (LAT=4, DEPTH=1024).
module tb_multicycle_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        flush;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_mem #(
        .DWIDTH (16),
        .AWIDTH (16),
        .DEPTH  (1024),
        .LAT    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        idle();
        tick();
        tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_data !== 16'h0) begin n_bad++; $display("FAIL reset_resp_data: got %h want 0000", resp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic exp_v;
        set_req(1'b1, 16'h0010, 16'hBEEF);
        tick();
        set_req(1'b0, 16'h0010, 16'h0);
        tick();
        idle();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_rd_busy: got %b want 1", busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = (k == 3);
            n_cmp++; if (resp_valid !== exp_v) begin n_bad++; $display("FAIL wr_rd_valid k=%0d: got %b want %b", k, resp_valid, exp_v); end
            if (k >= 3) begin
                n_cmp++; if (resp_data !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rd_data k=%0d: got %h want beef", k, resp_data); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_rd_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic        exp_v, exp_b;
        logic [15:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 16'(2 * i), 16'(16'h1111 * (i + 1)));
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) set_req(1'b0, 16'(2 * k), 16'h0);
            else       idle();
            tick();
            exp_b = (k <= 6);
            exp_v = (k >= 3) && (k <= 6);
            n_cmp++; if (busy !== exp_b) begin n_bad++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, exp_b); end
            n_cmp++; if (resp_valid !== exp_v) begin n_bad++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, resp_valid, exp_v); end
            if (exp_v) begin
                exp_d = 16'(16'h1111 * (k - 2));
                n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL b2b_data k=%0d: got %h want %h", k, resp_data, exp_d); end
            end
        end
    endtask

    task automatic test_flush();
        logic exp_v;
        set_req(1'b1, 16'h0008, 16'hA5A5); tick();
        set_req(1'b1, 16'h000A, 16'h5A5A); tick();
        set_req(1'b1, 16'h000C, 16'h0C0C); tick();
        set_req(1'b0, 16'h000A, 16'h0); tick();
        set_req(1'b0, 16'h000C, 16'h0); tick();
        set_req(1'b0, 16'h0008, 16'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy: got %b want 1", busy); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid k=0: got %b want 0", resp_valid); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = (k == 3);
            n_cmp++; if (resp_valid !== exp_v) begin n_bad++; $display("FAIL flush_valid k=%0d: got %b want %b", k, resp_valid, exp_v); end
            if (k < 3) begin
                n_cmp++; if (resp_data !== 16'h4444) begin n_bad++; $display("FAIL flush_hold k=%0d: got %h want 4444", k, resp_data); end
            end else if (k == 3) begin
                n_cmp++; if (resp_data !== 16'hA5A5) begin n_bad++; $display("FAIL flush_data: got %h want a5a5", resp_data); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        logic exp_v;
        set_req(1'b1, 16'h0802, 16'h1234);
        tick();
        set_req(1'b0, 16'h0002, 16'h0);
        tick();
        idle();
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_v = (k == 3);
            n_cmp++; if (resp_valid !== exp_v) begin n_bad++; $display("FAIL wrap_valid k=%0d: got %b want %b", k, resp_valid, exp_v); end
        end
        n_cmp++; if (resp_data !== 16'h1234) begin n_bad++; $display("FAIL wrap_data: got %h want 1234", resp_data); end
    endtask

    task automatic test_misaligned();
        logic [15:0] addrs [2];
        addrs[0] = 16'h0011;
        addrs[1] = 16'h0010;
        for (int j = 0; j < 2; j++) begin
            set_req(1'b0, addrs[j], 16'h0);
            tick();
            idle();
            tick();
            tick();
            tick();
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL misalign_valid addr=%h: got %b want 1", addrs[j], resp_valid); end
            n_cmp++; if (resp_data !== 16'hBEEF) begin n_bad++; $display("FAIL misalign_data addr=%h: got %h want beef", addrs[j], resp_data); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        set_req(1'b0, 16'h0004, 16'h0);
        tick();
        idle();
        tick();
        rst = 1'b1;
        set_req(1'b1, 16'h0004, 16'hDEAD);
        tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (resp_data !== 16'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 0000", resp_data); end
        rst = 1'b0;
        idle();
        seen = resp_valid;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | resp_valid;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resp: got %b want 0", seen); end
        n_cmp++; if (resp_data !== 16'h0) begin n_bad++; $display("FAIL midrst_data_hold: got %h want 0000", resp_data); end
        set_req(1'b0, 16'h0004, 16'h0);
        tick();
        idle();
        tick();
        tick();
        tick();
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL postrst_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_data !== 16'h3333) begin n_bad++; $display("FAIL postrst_data: got %h want 3333", resp_data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_misaligned();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_mem.md
MULTICYCLE_MEM -- requirements
Module: multicycle_mem

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter DWIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 16: byte-address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024: number of stored words.
REQ-004 SHALL have parameter LAT, default 4: fixed read latency in cycles, legal range 2..8.

Ports (name, direction, width, meaning):
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: the block can accept a request this cycle.
REQ-009 SHALL have port req_wr, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, AWIDTH: byte address; the word index is req_addr[AWIDTH-1:1].
REQ-011 SHALL have port req_wdata, input, DWIDTH: write data.
REQ-012 SHALL have port flush, input, 1: kill all in-flight reads.
REQ-013 SHALL have port resp_valid, output, 1: read data valid this cycle.
REQ-014 SHALL have port resp_data, output, DWIDTH: read data.
REQ-015 SHALL have port busy, output, 1: at least one read is in flight.

Function
REQ-016 SHALL accept a request on each rising edge where req_valid and req_ready are both 1; at most one request is accepted per cycle.
REQ-017 SHALL drive req_ready to 1 except during the cycle in which rst is asserted; no internal back-pressure exists.
REQ-018 SHALL commit an accepted write to the array at its accept edge; writes produce no response.
REQ-019 SHALL sample the array for an accepted read at its accept edge.
- A read accepted in the cycle after a write to the same word returns the new data.
- A read and a write cannot arrive in the same cycle.
REQ-020 SHALL present each accepted read's data with resp_valid=1 exactly LAT cycles after its accept edge, for one cycle only.
REQ-021 SHALL keep reads fully pipelined: up to LAT reads in flight, responses returned in accept order, back-to-back reads giving back-to-back responses.
REQ-022 SHALL hold resp_data at its previous value when resp_valid=0.
REQ-023 SHALL reduce out-of-range word indices (index >= DEPTH) modulo DEPTH, i.e. wrap-around.
REQ-024 SHALL, when flush=1 at an edge, clear every in-flight read so that no resp_valid is produced for it.
- A request accepted in the same cycle as flush is still processed.
- A write accepted in a flush cycle still commits.
REQ-025 SHALL drive busy combinationally as the OR of all in-flight valid bits.
REQ-026 SHALL, for a misaligned address (req_addr[0]=1), ignore bit 0 and access the word containing that byte.

Reset
REQ-027 SHALL, on an edge with rst=1, clear all in-flight valid bits, resp_valid to 0, resp_data to 0 and busy to 0.
REQ-028 SHALL leave array contents unchanged by rst.
REQ-029 SHALL ignore and drop any request presented while rst=1.
REQ-030 SHALL never produce a response for a read that was in flight when rst asserts mid-operation.

Structure
REQ-031 SHALL place the default widths and the default LAT value in the shared CPU package alongside the existing DWIDTH/AWIDTH constants.
REQ-032 SHALL instantiate one sub-module, lat_pipe: a LAT-deep valid/data shift register with synchronous clear, used for the read return path.

Verification
REQ-033 SHALL include a directed scenario: write 0xBEEF to address 0x0010, then read 0x0010 the next cycle -> resp_valid=1 with data 0xBEEF exactly 4 cycles after the read is accepted.
REQ-034 SHALL include a directed scenario: reads of 0x0000, 0x0002, 0x0004 and 0x0006 on 4 consecutive cycles, preloaded with 0x1111, 0x2222, 0x3333 and 0x4444 -> those four values returned on 4 consecutive cycles starting 4 cycles after the first read, with busy=1 throughout.
REQ-035 SHALL include a directed scenario: 2 reads in flight, then flush asserted together with a new read of 0x0008 (holding 0xA5A5) -> the 2 old responses are suppressed and only 0xA5A5 is returned, 4 cycles after the flush edge.
REQ-036 SHALL include a directed scenario: with DEPTH=1024, write 0x1234 to address 0x0802 -> a read of 0x0002 returns 0x1234, confirming wrap-around.
REQ-037 SHALL include a directed scenario: rst asserted 2 cycles after a read is accepted -> no resp_valid ever appears and resp_data=0, then a post-reset read returns the pre-reset array contents.
REQ-038 SHALL include a directed scenario: read of odd address 0x0011 -> returns the same word as a read of 0x0010.
